// File: rtl/jtgng_prom_dwnld.sv
// Download-side PROM writer: maps an address window of the ROM download stream
// onto NPROM write-port PROMs and reports load completion and byte-count errors.
module jtgng_prom_dwnld #(
  parameter int IOAW  = 22,
  parameter     START = 22'h0,
  parameter int AW    = 10,
  parameter int DW    = 8,
  parameter int NPROM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [IOAW-1:0]   ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              ioctl_wr,
  output logic [NPROM-1:0]  prom_we,
  output logic [AW-1:0]     prom_addr,
  output logic [DW-1:0]     prom_data,
  output logic [AW+3:0]     bytecnt,
  output logic              loaded,
  output logic              load_err
);

  localparam int IW = IOAW - AW;
  localparam logic [IOAW-1:0] START_A   = IOAW'(START);
  localparam logic [IW-1:0]   NPROM_IDX = IW'(NPROM);
  localparam logic [AW+3:0]   FULL_CNT  = (AW+4)'(NPROM) << AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             dl_l_q;
  logic [AW+3:0]    bytecnt_q, bytecnt_d;
  logic             loaded_q, loaded_d;
  logic             load_err_q, load_err_d;
  logic [NPROM-1:0] prom_we_q, prom_we_d;
  logic [AW-1:0]    prom_addr_q, prom_addr_d;
  logic [DW-1:0]    prom_data_q, prom_data_d;

  logic [IOAW-1:0]  off_s;
  logic [IW-1:0]    idx_s;
  logic             hit_s, accept_s, dl_rise_s, dl_fall_s;

  // Window decode; addresses below START wrap to a large offset and miss anyway
  always_comb begin
    off_s     = ioctl_addr - START_A;
    idx_s     = off_s[IOAW-1:AW];
    hit_s     = (ioctl_addr >= START_A) && (idx_s < NPROM_IDX);
    accept_s  = downloading && ioctl_wr && hit_s;
    dl_rise_s = downloading && !dl_l_q;
    dl_fall_s = !downloading && dl_l_q;
  end

  // PROM write strobe, address and data; address/data hold between writes
  always_comb begin
    prom_we_d   = {NPROM{1'b0}};
    prom_addr_d = prom_addr_q;
    prom_data_d = prom_data_q;
    if (accept_s) begin
      for (int i = 0; i < NPROM; i++) begin
        prom_we_d[i] = (idx_s == IW'(i));
      end
      prom_addr_d = off_s[AW-1:0];
      prom_data_d = ioctl_data[DW-1:0];
    end else begin
      prom_we_d = {NPROM{1'b0}};
    end
  end

  // Load-tracking FSM: next state, byte counter and status flags
  always_comb begin
    state_d    = state_q;
    bytecnt_d  = bytecnt_q;
    loaded_d   = loaded_q;
    load_err_d = load_err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (dl_rise_s) begin
          state_d    = ST_LOAD;
          loaded_d   = 1'b0;
          load_err_d = 1'b0;
          bytecnt_d  = accept_s ? (AW+4)'(1) : (AW+4)'(0);
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (dl_fall_s) begin
          state_d    = ST_DONE;
          loaded_d   = 1'b1;
          load_err_d = (bytecnt_q != FULL_CNT);
        end else if (accept_s && (bytecnt_q != {(AW+4){1'b1}})) begin
          bytecnt_d = bytecnt_q + (AW+4)'(1);
        end else begin
          bytecnt_d = bytecnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dl_l_q      <= 1'b0;
      bytecnt_q   <= {(AW+4){1'b0}};
      loaded_q    <= 1'b0;
      load_err_q  <= 1'b0;
      prom_we_q   <= {NPROM{1'b0}};
      prom_addr_q <= {AW{1'b0}};
      prom_data_q <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      dl_l_q      <= downloading;
      bytecnt_q   <= bytecnt_d;
      loaded_q    <= loaded_d;
      load_err_q  <= load_err_d;
      prom_we_q   <= prom_we_d;
      prom_addr_q <= prom_addr_d;
      prom_data_q <= prom_data_d;
    end
  end

  assign prom_we   = prom_we_q;
  assign prom_addr = prom_addr_q;
  assign prom_data = prom_data_q;
  assign bytecnt   = bytecnt_q;
  assign loaded    = loaded_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_jtgng_prom_dwnld.sv
// Directed bench for jtgng_prom_dwnld with START=0x100, AW=4, NPROM=2.
module tb_jtgng_prom_dwnld;

  localparam int IOAW = 22;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NPROM = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             downloading;
  logic [IOAW-1:0]  ioctl_addr;
  logic [7:0]       ioctl_data;
  logic             ioctl_wr;
  logic [NPROM-1:0] prom_we;
  logic [AW-1:0]    prom_addr;
  logic [DW-1:0]    prom_data;
  logic [AW+3:0]    bytecnt;
  logic             loaded;
  logic             load_err;

  int n_cmp = 0;
  int n_err = 0;

  jtgng_prom_dwnld #(
    .IOAW(IOAW), .START(22'h100), .AW(AW), .DW(DW), .NPROM(NPROM)
  ) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
    .bytecnt(bytecnt), .loaded(loaded), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one strobe at the falling edge, check the registered write just after the next rise
  task automatic stb(input logic [IOAW-1:0] a, input logic [1:0] exp_we);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_data = a[7:0];
    ioctl_wr   = 1'b1;
    @(posedge clk); #1;
    check_val($sformatf("we@%0h", a), 32'(prom_we), 32'(exp_we));
    if (exp_we != 2'b00) begin
      check_val($sformatf("addr@%0h", a), 32'(prom_addr), 32'(a[3:0]));
      check_val($sformatf("data@%0h", a), 32'(prom_data), 32'(a[7:0]));
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_dl(input logic v);
    @(negedge clk);
    ioctl_wr    = 1'b0;
    downloading = v;
    @(posedge clk); #1;
  endtask

  task automatic check_status(input string tag, input int cnt, input logic ld, input logic err);
    check_val({tag, "_cnt"}, 32'(bytecnt), 32'(cnt));
    check_val({tag, "_loaded"}, 32'(loaded), 32'(ld));
    check_val({tag, "_err"}, 32'(load_err), 32'(err));
  endtask

  function automatic logic [1:0] we_of(input logic [IOAW-1:0] a);
    if (a >= 22'h100 && a < 22'h110) return 2'b01;
    if (a >= 22'h110 && a < 22'h120) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    rst = 1'b1; downloading = 1'b0; ioctl_addr = '0; ioctl_data = 8'h00; ioctl_wr = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_val("rst_we", 32'(prom_we), 32'd0);
    check_status("rst", 0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Full load
    set_dl(1'b1);
    check_status("start", 0, 1'b0, 1'b0);
    for (int a = 'h100; a < 'h120; a++) stb(IOAW'(a), we_of(IOAW'(a)));
    idle_cycle();
    check_val("we_off", 32'(prom_we), 32'd0);
    check_val("cnt_pre_fall", 32'(bytecnt), 32'd32);
    set_dl(1'b0);
    check_status("full", 32, 1'b1, 1'b0);

    // Window edges
    set_dl(1'b1);
    check_status("reload_edges", 0, 1'b0, 1'b0);
    stb(22'h0FF, 2'b00);
    stb(22'h100, 2'b01);
    stb(22'h11F, 2'b10);
    stb(22'h120, 2'b00);
    idle_cycle();
    set_dl(1'b0);
    check_status("edges", 2, 1'b1, 1'b1);

    // Short load
    set_dl(1'b1);
    for (int a = 'h100; a < 'h110; a++) stb(IOAW'(a), 2'b01);
    idle_cycle();
    set_dl(1'b0);
    check_status("short", 16, 1'b1, 1'b1);

    // Back-to-back strobes, then gating by downloading
    set_dl(1'b1);
    stb(22'h105, 2'b01);
    stb(22'h106, 2'b01);
    stb(22'h107, 2'b01);
    check_val("b2b_cnt", 32'(bytecnt), 32'd3);
    @(negedge clk);
    downloading = 1'b0; ioctl_addr = 22'h108; ioctl_data = 8'h08; ioctl_wr = 1'b1;
    @(posedge clk); #1;
    check_val("fall_strobe_we", 32'(prom_we), 32'd0);
    check_status("fall_strobe", 3, 1'b1, 1'b1);
    stb(22'h109, 2'b00);
    check_val("gated_cnt", 32'(bytecnt), 32'd3);
    idle_cycle();

    // Reload with a full load
    set_dl(1'b1);
    check_status("reload", 0, 1'b0, 1'b0);
    for (int a = 'h100; a < 'h120; a++) stb(IOAW'(a), we_of(IOAW'(a)));
    idle_cycle();
    set_dl(1'b0);
    check_status("reload_full", 32, 1'b1, 1'b0);

    // Reset mid-load, released while still downloading
    set_dl(1'b1);
    for (int a = 'h100; a < 'h105; a++) stb(IOAW'(a), 2'b01);
    check_val("pre_rst_cnt", 32'(bytecnt), 32'd5);
    @(negedge clk);
    ioctl_addr = 22'h105; ioctl_data = 8'h05; ioctl_wr = 1'b1;
    rst = 1'b1;
    #1;
    check_val("rst_mid_we", 32'(prom_we), 32'd0);
    check_status("rst_mid", 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_val("rst_hold_we", 32'(prom_we), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_val("rel_we", 32'(prom_we), 32'd1);
    check_val("rel_addr", 32'(prom_addr), 32'd5);
    check_status("rel", 1, 1'b0, 1'b0);
    for (int a = 'h106; a < 'h120; a++) stb(IOAW'(a), we_of(IOAW'(a)));
    idle_cycle();
    set_dl(1'b0);
    check_status("after_rst", 27, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
